// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: pointer width and parameter legality checks.
package fifo_pkg;

   // Pointers carry one extra wrap bit above the storage address.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

   function automatic bit fifo_params_ok(input int depth, input int ae_level, input int af_level);
      return is_pow2(depth) && (depth >= 4) && (ae_level < af_level) && (af_level <= depth);
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W storage: synchronous write port, combinational read port.
module fifo_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 64,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with programmable almost-full/empty thresholds, over/underflow
// pulses and a selectable standard or first-word-fall-through read port.
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 64,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2,
   parameter int FWFT     = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_W-1:0]        in,
   input  logic                     wr,
   input  logic                     rd,
   output logic [DATA_W-1:0]        out,
   output logic [$clog2(DEPTH):0]   fifo_cnt,
   output logic                     empty,
   output logic                     full,
   output logic                     almost_empty,
   output logic                     almost_full,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int PW = ptr_w(DEPTH);
   localparam int AW = PW - 1;
   localparam logic [PW-1:0] DEPTH_L = PW'(DEPTH);
   localparam logic [PW-1:0] AF_L    = PW'(AF_LEVEL);
   localparam logic [PW-1:0] AE_L    = PW'(AE_LEVEL);

   if (!fifo_params_ok(DEPTH, AE_LEVEL, AF_LEVEL)) begin : g_bad_params
      $error("sync_fifo_param: DEPTH must be a power of two >= 4 and AE_LEVEL < AF_LEVEL <= DEPTH");
   end

   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt_q, cnt_d;
   logic              empty_q, full_q, ae_q, af_q, ovf_q, unf_q;
   logic              wr_ok, rd_ok;
   logic [DATA_W-1:0] ram_rdata;

   // A full FIFO still takes a write when a read frees a slot in the same cycle.
   always_comb begin
      rd_ok    = rd & ~empty_q;
      wr_ok    = wr & (~full_q | rd_ok);
      wr_ptr_d = wr_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = rd_ok ? rd_ptr_q + PW'(1) : rd_ptr_q;
      cnt_d    = cnt_q;
      case ({wr_ok, rd_ok})
         2'b10:   cnt_d = cnt_q + PW'(1);
         2'b01:   cnt_d = cnt_q - PW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         ae_q     <= 1'b1;
         af_q     <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         empty_q  <= (cnt_d == '0);
         full_q   <= (cnt_d == DEPTH_L);
         ae_q     <= (cnt_d <= AE_L);
         af_q     <= (cnt_d >= AF_L);
         ovf_q    <= wr & ~wr_ok;
         unf_q    <= rd & ~rd_ok;
      end
   end

   fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clk     (clk),
      .we_i    (wr_ok),
      .waddr_i (wr_ptr_q[AW-1:0]),
      .wdata_i (in),
      .raddr_i (rd_ptr_q[AW-1:0]),
      .rdata_o (ram_rdata)
   );

   if (FWFT != 0) begin : g_fwft
      // Head entry falls through; forced to zero while empty so reset shows 0.
      assign out = empty_q ? '0 : ram_rdata;
   end else begin : g_std
      logic [DATA_W-1:0] out_q;
      always_ff @(posedge clk or posedge rst) begin
         if (rst)        out_q <= '0;
         else if (rd_ok) out_q <= ram_rdata;
      end
      assign out = out_q;
   end

   assign fifo_cnt     = cnt_q;
   assign empty        = empty_q;
   assign full         = full_q;
   assign almost_empty = ae_q;
   assign almost_full  = af_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: standard and FWFT instances share stimulus and are
// compared against a queue-based model plus a table of hand-derived vectors.
module tb_sync_fifo_param;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] din = 8'h00;
   logic       wr  = 1'b0;
   logic       rd  = 1'b0;

   logic [7:0] out0, out1;
   logic [3:0] cnt0, cnt1;
   logic       e0, f0, ae0, af0, ov0, un0;
   logic       e1, f1, ae1, af1, ov1, un1;

   int checks = 0;
   int errors = 0;

   // Behavioural model: occupancy is a queue, standard-mode out is the last popped word.
   bit [7:0] q[$];
   bit [7:0] exp_out0;

   always #5 clk = ~clk;

   sync_fifo_param #(.DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) dut0 (
      .clk(clk), .rst(rst), .in(din), .wr(wr), .rd(rd), .out(out0), .fifo_cnt(cnt0),
      .empty(e0), .full(f0), .almost_empty(ae0), .almost_full(af0),
      .overflow(ov0), .underflow(un0));

   sync_fifo_param #(.DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) dut1 (
      .clk(clk), .rst(rst), .in(din), .wr(wr), .rd(rd), .out(out1), .fifo_cnt(cnt1),
      .empty(e1), .full(f1), .almost_empty(ae1), .almost_full(af1),
      .overflow(ov1), .underflow(un1));

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model(input bit ovf, input bit unf);
      int n;
      n = q.size();
      chk("cnt0", int'(cnt0), n);
      chk("cnt1", int'(cnt1), n);
      chk("empty0", int'(e0), int'(n == 0));
      chk("empty1", int'(e1), int'(n == 0));
      chk("full0", int'(f0), int'(n == 8));
      chk("full1", int'(f1), int'(n == 8));
      chk("aempty0", int'(ae0), int'(n <= 2));
      chk("aempty1", int'(ae1), int'(n <= 2));
      chk("afull0", int'(af0), int'(n >= 6));
      chk("afull1", int'(af1), int'(n >= 6));
      chk("ovf0", int'(ov0), int'(ovf));
      chk("ovf1", int'(ov1), int'(ovf));
      chk("unf0", int'(un0), int'(unf));
      chk("unf1", int'(un1), int'(unf));
      chk("out_std", int'(out0), int'(exp_out0));
      if (n > 0) chk("out_fwft", int'(out1), int'(q[0]));
   endtask

   task automatic step(input bit w, input bit r, input bit [7:0] d);
      bit rok, wok;
      wr = w; rd = r; din = d;
      @(posedge clk);
      #1;
      rok = r && (q.size() > 0);
      wok = w && ((q.size() < 8) || rok);
      if (rok) exp_out0 = q.pop_front();
      if (wok) q.push_back(d);
      check_model(w && !wok, r && !rok);
      wr = 1'b0; rd = 1'b0;
   endtask

   // Reset is raised between edges so its effect must be visible before any clock.
   task automatic do_reset();
      wr = 1'b0; rd = 1'b0;
      rst = 1'b1;
      #2;
      chk("rst_cnt0", int'(cnt0), 0);
      chk("rst_cnt1", int'(cnt1), 0);
      chk("rst_empty0", int'(e0), 1);
      chk("rst_empty1", int'(e1), 1);
      chk("rst_full0", int'(f0), 0);
      chk("rst_ae0", int'(ae0), 1);
      chk("rst_af0", int'(af0), 0);
      chk("rst_ovf0", int'(ov0), 0);
      chk("rst_unf0", int'(un0), 0);
      chk("rst_out0", int'(out0), 0);
      chk("rst_out1", int'(out1), 0);
      q.delete();
      exp_out0 = 8'h00;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   typedef struct {
      bit       wr;
      bit       rd;
      bit [7:0] din;
      int       cnt;
      bit       emp, ful, ae, af, ovf, unf;
      bit [7:0] dout;
   } vec_t;

   vec_t vecs[13];

   initial begin
      //            wr rd din     cnt emp ful ae af ovf unf out
      vecs[0]  = '{1, 0, 8'ha1, 1,  0,  0,  1, 0, 0,  0,  8'h00};
      vecs[1]  = '{1, 0, 8'h1b, 2,  0,  0,  1, 0, 0,  0,  8'h00};
      vecs[2]  = '{1, 0, 8'hee, 3,  0,  0,  0, 0, 0,  0,  8'h00};
      vecs[3]  = '{1, 0, 8'h55, 4,  0,  0,  0, 0, 0,  0,  8'h00};
      vecs[4]  = '{1, 0, 8'hbf, 5,  0,  0,  0, 0, 0,  0,  8'h00};
      vecs[5]  = '{0, 1, 8'h00, 4,  0,  0,  0, 0, 0,  0,  8'ha1};
      vecs[6]  = '{0, 1, 8'h00, 3,  0,  0,  0, 0, 0,  0,  8'h1b};
      vecs[7]  = '{0, 1, 8'h00, 2,  0,  0,  1, 0, 0,  0,  8'hee};
      vecs[8]  = '{0, 1, 8'h00, 1,  0,  0,  1, 0, 0,  0,  8'h55};
      vecs[9]  = '{0, 1, 8'h00, 0,  1,  0,  1, 0, 0,  0,  8'hbf};
      vecs[10] = '{0, 1, 8'h00, 0,  1,  0,  1, 0, 0,  1,  8'hbf};
      vecs[11] = '{1, 1, 8'h3c, 1,  0,  0,  1, 0, 0,  1,  8'hbf};
      vecs[12] = '{0, 1, 8'h00, 0,  1,  0,  1, 0, 0,  0,  8'h3c};

      exp_out0 = 8'h00;
      #7;
      do_reset();

      // Basic write/read order, underflow, simultaneous wr+rd on empty.
      for (int i = 0; i < 13; i++) begin
         step(vecs[i].wr, vecs[i].rd, vecs[i].din);
         chk($sformatf("vec%0d_cnt", i), int'(cnt0), vecs[i].cnt);
         chk($sformatf("vec%0d_empty", i), int'(e0), int'(vecs[i].emp));
         chk($sformatf("vec%0d_full", i), int'(f0), int'(vecs[i].ful));
         chk($sformatf("vec%0d_ae", i), int'(ae0), int'(vecs[i].ae));
         chk($sformatf("vec%0d_af", i), int'(af0), int'(vecs[i].af));
         chk($sformatf("vec%0d_ovf", i), int'(ov0), int'(vecs[i].ovf));
         chk($sformatf("vec%0d_unf", i), int'(un0), int'(vecs[i].unf));
         chk($sformatf("vec%0d_out", i), int'(out0), int'(vecs[i].dout));
      end

      // Fill, overflow on the ninth write, drain.
      do_reset();
      for (int i = 0; i < 8; i++) step(1, 0, 8'(i));
      chk("fill_full", int'(f0), 1);
      step(1, 0, 8'hff);
      chk("ovf_pulse", int'(ov0), 1);
      chk("ovf_cnt", int'(cnt0), 8);
      step(0, 0, 8'h00);
      chk("ovf_single", int'(ov0), 0);
      for (int i = 0; i < 8; i++) begin
         step(0, 1, 8'h00);
         chk("drain_out", int'(out0), i);
      end

      // Full FIFO with simultaneous write and read.
      do_reset();
      for (int i = 0; i < 8; i++) step(1, 0, 8'(i));
      for (int i = 0; i < 4; i++) begin
         step(1, 1, 8'haa);
         chk("fullrw_out", int'(out0), i);
         chk("fullrw_full", int'(f0), 1);
         chk("fullrw_ovf", int'(ov0), 0);
      end
      for (int i = 0; i < 8; i++) begin
         step(0, 1, 8'h00);
         chk("fullrw_drain", int'(out0), (i < 4) ? i + 4 : 8'haa);
      end

      // Interleaved pairs wrapping the pointers, then reset mid-stream.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         step(1, 0, 8'(8'h10 + i));
         step(0, 1, 8'h00);
         chk("wrap_out", int'(out0), 8'h10 + i);
      end
      step(1, 0, 8'h77);
      step(1, 0, 8'h88);
      do_reset();
      step(1, 0, 8'h99);
      step(0, 1, 8'h00);
      chk("post_rst_out", int'(out0), 8'h99);

      // FWFT: word shows up without a read, empty follows the pop.
      do_reset();
      step(1, 0, 8'h5a);
      chk("fwft_out", int'(out1), 8'h5a);
      chk("fwft_empty", int'(e1), 0);
      chk("std_out_unchanged", int'(out0), 0);
      step(0, 1, 8'h00);
      chk("fwft_empty_after_rd", int'(e1), 1);

      // Randomized traffic with phases biased toward filling and draining.
      do_reset();
      for (int ph = 0; ph < 8; ph++) begin
         int pw, pr;
         pw = (ph % 2 == 0) ? 75 : 30;
         pr = (ph % 2 == 0) ? 30 : 75;
         for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr), 8'($urandom));
         end
         if (ph == 5) do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
